// File: rtl/tile_map_renderer.sv
// tile_map_renderer
// -----------------------------------------------------------------------------
// Walks a MAP_W x MAP_H tile map stored in an external synchronous memory and
// produces one vga_adapter plot-interface pixel per DRAW cycle. Each tile code
// selects a colour from a runtime palette. The render can be offset by a pixel
// origin. Pixels that fall off screen are clipped. Code 0 can optionally be
// transparent. A pause input freezes pixel stepping.
//
// Handshake (start/busy/done):
//   start is sampled only in IDLE. A high start there is "accepted". busy is
//   high from the cycle after acceptance through the last DRAW cycle. done is
//   a single-cycle pulse in the DONE state, with busy low. A start seen while
//   busy, or in the DONE cycle, is ignored. There is no backpressure from the
//   VGA side: plot is a fire-and-forget write strobe.
//
// Ports:
//   clock       system clock
//   resetn      synchronous active-low reset
//   start       begin a full map render (IDLE only)
//   pause       freeze pixel stepping while high (DRAW only)
//   origin_x/y  screen position of tile (0,0), latched at start
//   palette     entry i at bits [i*COLOR_W +: COLOR_W], sampled live
//   map_addr    map memory read address (row*MAP_W + col)
//   map_q       map memory read data, RD_LAT cycles after the address
//   vga_x/y     pixel coordinate, holds its last value outside DRAW
//   vga_color   pixel colour, holds its last value outside DRAW
//   plot        write strobe for vga_adapter
//   busy        render in progress
//   done        one-cycle completion pulse
//   dbg_state_o current FSM state encoding, for observation only
// -----------------------------------------------------------------------------
module tile_map_renderer #(
   parameter int TILE_LOG2 = 3,
   parameter int MAP_W     = 29,
   parameter int MAP_H     = 13,
   parameter int CODE_W    = 2,
   parameter int COLOR_W   = 3,
   parameter int ADDR_W    = 9,
   parameter int RD_LAT    = 1,
   parameter int SCREEN_W  = 320,
   parameter int SCREEN_H  = 240,
   parameter int TRANSP0   = 0
) (
   input  logic                              clock,
   input  logic                              resetn,
   input  logic                              start,
   input  logic                              pause,
   input  logic [8:0]                        origin_x,
   input  logic [7:0]                        origin_y,
   input  logic [(2**CODE_W)*COLOR_W-1:0]    palette,
   output logic [ADDR_W-1:0]                 map_addr,
   input  logic [CODE_W-1:0]                 map_q,
   output logic [8:0]                        vga_x,
   output logic [7:0]                        vga_y,
   output logic [COLOR_W-1:0]                vga_color,
   output logic                              plot,
   output logic                              busy,
   output logic                              done,
   output logic [2:0]                        dbg_state_o
);

   localparam int COL_W = (MAP_W > 1) ? $clog2(MAP_W) : 1;
   localparam int ROW_W = (MAP_H > 1) ? $clog2(MAP_H) : 1;

   localparam logic [COL_W-1:0]     COL_LAST = COL_W'(MAP_W - 1);
   localparam logic [ROW_W-1:0]     ROW_LAST = ROW_W'(MAP_H - 1);
   localparam logic [COL_W-1:0]     COL_ONE  = COL_W'(1);
   localparam logic [ROW_W-1:0]     ROW_ONE  = ROW_W'(1);
   localparam logic [TILE_LOG2-1:0] D_ONE    = TILE_LOG2'(1);
   localparam logic [ADDR_W-1:0]    A_ONE    = ADDR_W'(1);
   localparam logic [1:0]           LAT_LAST = 2'(RD_LAT - 1);
   localparam logic [1:0]           LAT_ONE  = 2'd1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_DRAW  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic [COL_W-1:0]       col_q, col_d;
   logic [ROW_W-1:0]       row_q, row_d;
   logic [TILE_LOG2-1:0]   dx_q, dx_d;
   logic [TILE_LOG2-1:0]   dy_q, dy_d;
   logic [8:0]             ox_q, ox_d;
   logic [7:0]             oy_q, oy_d;
   logic [CODE_W-1:0]      code_q, code_d;
   logic [1:0]             lat_q, lat_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic [8:0]             hx_q, hx_d;
   logic [7:0]             hy_q, hy_d;
   logic [COLOR_W-1:0]     hc_q, hc_d;

   logic [9:0]             pix_x;
   logic [8:0]             pix_y;
   logic [COLOR_W-1:0]     pix_c;
   logic                   visible;
   logic                   transp;
   logic                   last_col;
   logic                   last_row;

   // Screen coordinates are one bit wider than the ports so that clipping
   // sees the true position rather than a wrapped one.
   assign pix_x    = 10'(ox_q) + (10'(col_q) << TILE_LOG2) + 10'(dx_q);
   assign pix_y    = 9'(oy_q) + (9'(row_q) << TILE_LOG2) + 9'(dy_q);
   assign pix_c    = palette[int'(code_q)*COLOR_W +: COLOR_W];
   assign visible  = (pix_x < 10'(SCREEN_W)) && (pix_y < 9'(SCREEN_H));
   assign transp   = (TRANSP0 != 0) && (code_q == '0);
   assign last_col = (col_q == COL_LAST);
   assign last_row = (row_q == ROW_LAST);

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      ox_d    = ox_q;
      oy_d    = oy_q;
      code_d  = code_q;
      lat_d   = lat_q;
      addr_d  = addr_q;
      hx_d    = hx_q;
      hy_d    = hy_q;
      hc_d    = hc_q;
      plot    = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               ox_d    = origin_x;
               oy_d    = origin_y;
               col_d   = '0;
               row_d   = '0;
               dx_d    = '0;
               dy_d    = '0;
               addr_d  = '0;
               state_d = S_FETCH;
            end
         end

         S_FETCH: begin
            busy    = 1'b1;
            lat_d   = '0;
            state_d = S_WAIT;
         end

         S_WAIT: begin
            busy = 1'b1;
            // Memory data is valid in the last of the RD_LAT wait cycles.
            if (lat_q == LAT_LAST) begin
               code_d  = map_q;
               state_d = S_DRAW;
            end else begin
               lat_d = lat_q + LAT_ONE;
            end
         end

         S_DRAW: begin
            busy = 1'b1;
            // Track the live pixel so the outputs can hold it after DRAW ends.
            hx_d = pix_x[8:0];
            hy_d = pix_y[7:0];
            hc_d = pix_c;
            plot = !pause && visible && !transp;
            if (!pause) begin
               if (dx_q != '1) begin
                  dx_d = dx_q + D_ONE;
               end else begin
                  dx_d = '0;
                  if (dy_q != '1) begin
                     dy_d = dy_q + D_ONE;
                  end else begin
                     dy_d = '0;
                     if (last_col && last_row) begin
                        state_d = S_DONE;
                     end else begin
                        // The address runs alongside col/row so no multiply
                        // is needed to form row*MAP_W + col.
                        state_d = S_FETCH;
                        addr_d  = addr_q + A_ONE;
                        if (last_col) begin
                           col_d = '0;
                           row_d = row_q + ROW_ONE;
                        end else begin
                           col_d = col_q + COL_ONE;
                        end
                     end
                  end
               end
            end
         end

         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         col_q   <= '0;
         row_q   <= '0;
         dx_q    <= '0;
         dy_q    <= '0;
         ox_q    <= '0;
         oy_q    <= '0;
         code_q  <= '0;
         lat_q   <= '0;
         addr_q  <= '0;
         hx_q    <= '0;
         hy_q    <= '0;
         hc_q    <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         ox_q    <= ox_d;
         oy_q    <= oy_d;
         code_q  <= code_d;
         lat_q   <= lat_d;
         addr_q  <= addr_d;
         hx_q    <= hx_d;
         hy_q    <= hy_d;
         hc_q    <= hc_d;
      end
   end

   assign map_addr    = addr_q;
   assign vga_x       = (state_q == S_DRAW) ? pix_x[8:0] : hx_q;
   assign vga_y       = (state_q == S_DRAW) ? pix_y[7:0] : hy_q;
   assign vga_color   = (state_q == S_DRAW) ? pix_c : hc_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_tile_map_renderer.sv
// Bench for tile_map_renderer in a 2x2 map, 2x2-pixel tile configuration.
// Three instances share stimulus: RD_LAT=1, RD_LAT=1 with transparent code 0,
// and RD_LAT=3. Each has its own map memory model and expected pixel queue.
module tb_tile_map_renderer;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic       resetn;
   logic       start;
   logic       pause;
   logic [8:0] origin_x;
   logic [7:0] origin_y;
   logic [11:0] palette;

   logic [2:0] ma [3];
   logic [8:0] vx [3];
   logic [7:0] vy [3];
   logic [2:0] vc [3];
   logic       pl [3];
   logic       bz [3];
   logic       dn [3];
   logic [2:0] st [3];

   // ---------------- map memory models ----------------
   logic [1:0] map_mem [8];
   logic [2:0] pal_tab [4];
   logic [1:0] r0, rt, r3a, r3b, r3c;

   always @(posedge clock) begin
      r0  <= map_mem[ma[0]];
      rt  <= map_mem[ma[1]];
      r3a <= map_mem[ma[2]];
      r3b <= r3a;
      r3c <= r3b;
   end

   tile_map_renderer #(.TILE_LOG2(1), .MAP_W(2), .MAP_H(2), .CODE_W(2), .COLOR_W(3),
      .ADDR_W(3), .RD_LAT(1), .SCREEN_W(320), .SCREEN_H(240), .TRANSP0(0)) dut (
      .clock(clock), .resetn(resetn), .start(start), .pause(pause),
      .origin_x(origin_x), .origin_y(origin_y), .palette(palette),
      .map_addr(ma[0]), .map_q(r0), .vga_x(vx[0]), .vga_y(vy[0]), .vga_color(vc[0]),
      .plot(pl[0]), .busy(bz[0]), .done(dn[0]), .dbg_state_o(st[0]));

   tile_map_renderer #(.TILE_LOG2(1), .MAP_W(2), .MAP_H(2), .CODE_W(2), .COLOR_W(3),
      .ADDR_W(3), .RD_LAT(1), .SCREEN_W(320), .SCREEN_H(240), .TRANSP0(1)) dut_t (
      .clock(clock), .resetn(resetn), .start(start), .pause(pause),
      .origin_x(origin_x), .origin_y(origin_y), .palette(palette),
      .map_addr(ma[1]), .map_q(rt), .vga_x(vx[1]), .vga_y(vy[1]), .vga_color(vc[1]),
      .plot(pl[1]), .busy(bz[1]), .done(dn[1]), .dbg_state_o(st[1]));

   tile_map_renderer #(.TILE_LOG2(1), .MAP_W(2), .MAP_H(2), .CODE_W(2), .COLOR_W(3),
      .ADDR_W(3), .RD_LAT(3), .SCREEN_W(320), .SCREEN_H(240), .TRANSP0(0)) dut_l3 (
      .clock(clock), .resetn(resetn), .start(start), .pause(pause),
      .origin_x(origin_x), .origin_y(origin_y), .palette(palette),
      .map_addr(ma[2]), .map_q(r3c), .vga_x(vx[2]), .vga_y(vy[2]), .vga_color(vc[2]),
      .plot(pl[2]), .busy(bz[2]), .done(dn[2]), .dbg_state_o(st[2]));

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_err    = 0;

   logic [19:0] exp_q [$];
   logic [19:0] exp_qt [$];
   logic [19:0] exp_q3 [$];
   logic [19:0] rec0 [$];

   int done_at [3];
   int done_cnt [3];
   int plot_cnt [3];

   logic [8:0] sx [64];
   logic [7:0] sy [64];
   logic [2:0] sc [64];
   logic [2:0] sa0 [64];
   logic [2:0] sa3 [64];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic take(input int i, input logic [19:0] px);
      logic [19:0] e;
      e = '1;
      case (i)
         0:       if (exp_q.size() > 0)  e = exp_q.pop_front();
         1:       if (exp_qt.size() > 0) e = exp_qt.pop_front();
         default: if (exp_q3.size() > 0) e = exp_q3.pop_front();
      endcase
      check($sformatf("pixel_dut%0d", i), 32'(px), 32'(e));
   endtask

   function automatic logic [19:0] get_rec(input int k);
      if (k < rec0.size()) return rec0[k];
      return '1;
   endfunction

   // Expected plotted pixels, raster order within each tile, tiles row-major.
   task automatic build_exp(input int ox, input int oy);
      int x, y, code;
      logic [8:0]  x9;
      logic [7:0]  y8;
      logic [19:0] px;
      exp_q.delete(); exp_qt.delete(); exp_q3.delete(); rec0.delete();
      for (int row = 0; row < 2; row++)
         for (int col = 0; col < 2; col++) begin
            code = int'(map_mem[row*2+col]);
            for (int dy = 0; dy < 2; dy++)
               for (int dx = 0; dx < 2; dx++) begin
                  x  = ox + col*2 + dx;
                  y  = oy + row*2 + dy;
                  x9 = x[8:0];
                  y8 = y[7:0];
                  px = {x9, y8, pal_tab[code]};
                  if (x < 320 && y < 240) begin
                     exp_q.push_back(px);
                     exp_q3.push_back(px);
                     if (code != 0) exp_qt.push_back(px);
                  end
               end
         end
   endtask

   // ---------------- driver ----------------
   task automatic run_case(input string name, input int ox, input int oy,
                           input int p_start, input int p_len, input int rs_at,
                           input int re1, input int re2,
                           input int ed0, input int edt, input int ed3,
                           input int np0, input int npt, input int np3);
      int ed [3];
      int np [3];
      ed = '{ed0, edt, ed3};
      np = '{np0, npt, np3};
      build_exp(ox, oy);
      for (int i = 0; i < 3; i++) begin
         done_at[i] = -1; done_cnt[i] = 0; plot_cnt[i] = 0;
      end
      @(negedge clock);
      origin_x = ox[8:0];
      origin_y = oy[7:0];
      start    = 1'b1;
      for (int c = 1; c < 48; c++) begin
         @(negedge clock);
         start    = (c == re1) || (c == re2);
         pause    = (c >= p_start) && (c < p_start + p_len);
         resetn   = (c != rs_at);
         // Origin moves after acceptance must not matter.
         origin_x = 9'(c);
         origin_y = 8'(c);
         #1;
         for (int i = 0; i < 3; i++) begin
            if (pl[i] === 1'b1) begin
               plot_cnt[i]++;
               take(i, {vx[i], vy[i], vc[i]});
            end
            if (dn[i] === 1'b1) begin
               done_cnt[i]++;
               if (done_at[i] < 0) done_at[i] = c;
               check($sformatf("%s_busy_at_done%0d", name, i), 32'(bz[i]), 32'd0);
            end
            if (c == 1) check($sformatf("%s_busy_c1_%0d", name, i), 32'(bz[i]), 32'd1);
            if (c == rs_at + 1) begin
               check($sformatf("%s_rst_busy%0d", name, i), 32'(bz[i]), 32'd0);
               check($sformatf("%s_rst_plot%0d", name, i), 32'(pl[i]), 32'd0);
            end
         end
         if (pl[0] === 1'b1) rec0.push_back({vx[0], vy[0], vc[0]});
         if (pause) check($sformatf("%s_pause_plot", name), 32'(pl[0]), 32'd0);
         sx[c] = vx[0]; sy[c] = vy[0]; sc[c] = vc[0];
         sa0[c] = ma[0]; sa3[c] = ma[2];
      end
      pause  = 1'b0;
      start  = 1'b0;
      resetn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("%s_done_at%0d", name, i), 32'(done_at[i]), 32'(ed[i]));
         check($sformatf("%s_done_cnt%0d", name, i), 32'(done_cnt[i]), (ed[i] < 0) ? 32'd0 : 32'd1);
         check($sformatf("%s_plots%0d", name, i), 32'(plot_cnt[i]), 32'(np[i]));
      end
      if (ed0 >= 0)
         check($sformatf("%s_leftover", name),
               32'(exp_q.size() + exp_qt.size() + exp_q3.size()), 32'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      map_mem = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
      pal_tab = '{3'b000, 3'b100, 3'b010, 3'b001};
      palette = {pal_tab[3], pal_tab[2], pal_tab[1], pal_tab[0]};
      resetn = 1'b0; start = 1'b0; pause = 1'b0;
      origin_x = '0; origin_y = '0;
      repeat (3) @(negedge clock);
      resetn = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rst_addr%0d", i),  32'(ma[i]), 32'd0);
         check($sformatf("rst_x%0d", i),     32'(vx[i]), 32'd0);
         check($sformatf("rst_y%0d", i),     32'(vy[i]), 32'd0);
         check($sformatf("rst_color%0d", i), 32'(vc[i]), 32'd0);
         check($sformatf("rst_plot%0d", i),  32'(pl[i]), 32'd0);
         check($sformatf("rst_busy%0d", i),  32'(bz[i]), 32'd0);
         check($sformatf("rst_done%0d", i),  32'(dn[i]), 32'd0);
         check($sformatf("rst_state%0d", i), 32'(st[i]), 32'd0);
      end

      // Basic render: 25 cycles to done (33 with RD_LAT=3).
      run_case("basic", 10, 20, 99, 0, -5, -1, -1, 25, 25, 33, 16, 12, 16);
      check("first_px",  32'(get_rec(0)),  32'({9'd10, 8'd20, 3'b100}));
      check("second_px", 32'(get_rec(1)),  32'({9'd11, 8'd20, 3'b100}));
      check("third_px",  32'(get_rec(2)),  32'({9'd10, 8'd21, 3'b100}));
      check("fourth_px", 32'(get_rec(3)),  32'({9'd11, 8'd21, 3'b100}));
      check("tile1_px",  32'(get_rec(4)),  32'({9'd12, 8'd20, 3'b000}));
      check("last_px",   32'(get_rec(15)), 32'({9'd13, 8'd23, 3'b001}));
      check("hold_x",     32'(sx[25]), 32'd13);
      check("hold_y",     32'(sy[25]), 32'd23);
      check("hold_color", 32'(sc[25]), 32'b001);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("addr_l1_t%0d", k), 32'(sa0[6*k+1]), 32'(k));
         for (int j = 1; j <= 4; j++)
            check($sformatf("addr_l3_t%0d_c%0d", k, j), 32'(sa3[8*k+j]), 32'(k));
      end

      // start re-pulsed while busy and in the DONE cycle.
      run_case("restart", 10, 20, 99, 0, -5, 5, 25, 25, 25, 33, 16, 12, 16);

      // Clipping at the bottom-right corner of the screen.
      run_case("clip", 318, 238, 99, 0, -5, -1, -1, 25, 25, 33, 4, 4, 4);
      check("clip_last_x", 32'(sx[24]), 32'd321);
      check("clip_last_y", 32'(sy[24]), 32'd241);

      // Pause 5 cycles inside tile 2 (DRAW for RD_LAT=1 instances).
      run_case("pause", 10, 20, 16, 5, -5, -1, -1, 30, 30, 38, 16, 12, 16);

      // Pause during the RD_LAT=3 instance's FETCH/WAIT of tile 1.
      run_case("pause_fw", 10, 20, 9, 4, -5, -1, -1, 29, 29, 33, 16, 12, 16);

      // Reset mid-DRAW: abort, no done.
      run_case("reset", 10, 20, 99, 0, 10, -1, -1, -1, -1, -1, 6, 4, 4);

      // Full render after the abort.
      run_case("after_rst", 10, 20, 99, 0, -5, -1, -1, 25, 25, 33, 16, 12, 16);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
